// File: rtl/proximity_alert.sv
// proximity_alert: averages ultrasonic echo widths, classifies the distance
// into CLEAR / FAR / NEAR zones with hysteresis and drives the helmet buzzer,
// an alert line and a stale-sensor flag.
// Optional build macro PROX_DIST_CM_EN adds a serial avg_us/58 divider that
// reports the averaged distance in centimetres on dist_cm / dist_valid.
//
// Handshake: pulse_valid is a one-cycle strobe with no back-pressure; every
// strobe is accepted (back-to-back included). avg_valid and dist_valid are
// one-cycle strobes qualifying avg_us and dist_cm respectively.
module proximity_alert #(
    parameter int PW_WIDTH       = 15,
    parameter int AVG_LOG2       = 2,
    parameter int NEAR_US        = 580,
    parameter int FAR_US         = 2900,
    parameter int HYST_US        = 116,
    parameter int STALE_US       = 100000,
    parameter int BEEP_ON_US     = 100000,
    parameter int BEEP_PERIOD_US = 500000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tick_us,
    input  logic [PW_WIDTH-1:0] pulse_in,
    input  logic                pulse_valid,
    output logic [PW_WIDTH-1:0] avg_us,
    output logic                avg_valid,
    output logic [1:0]          level,
    output logic                alert,
    output logic                buzz,
    output logic                stale,
    output logic [9:0]          dist_cm,
    output logic                dist_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = PW_WIDTH + AVG_LOG2;
    localparam int CW    = PW_WIDTH + 1;
    localparam int SCW   = $clog2(STALE_US + 1);
    localparam int BW    = $clog2(BEEP_PERIOD_US + 1);

    localparam logic [PW_WIDTH-1:0] PW_MAX   = '1;
    localparam logic [SW-1:0]       SUM_FULL = SW'(DEPTH * ((1 << PW_WIDTH) - 1));

    localparam logic [CW-1:0] NEAR_ENTER = CW'(NEAR_US);
    localparam logic [CW-1:0] FAR_ENTER  = CW'(FAR_US);
    localparam logic [CW-1:0] NEAR_EXIT  = CW'(NEAR_US + HYST_US);
    localparam logic [CW-1:0] FAR_EXIT   = CW'(FAR_US + HYST_US);

    localparam logic [SCW-1:0] STALE_MAX  = SCW'(STALE_US);
    localparam logic [SCW-1:0] STALE_LAST = SCW'(STALE_US - 1);
    localparam logic [BW-1:0]  BEEP_LAST  = BW'(BEEP_PERIOD_US - 1);
    localparam logic [BW-1:0]  BEEP_ON    = BW'(BEEP_ON_US);

    // Zone FSM encoding; the state register is the level output itself.
    localparam logic [1:0] LVL_CLEAR = 2'd0;
    localparam logic [1:0] LVL_FAR   = 2'd1;
    localparam logic [1:0] LVL_NEAR  = 2'd2;

    logic [PW_WIDTH-1:0] sample_buf [DEPTH];
    logic [SW-1:0]       sum;
    logic                s1_valid;
    logic [PW_WIDTH-1:0] sample_cond;
    logic [SCW-1:0]      stale_cnt;
    logic                stale_hit;
    logic [BW-1:0]       beep_cnt;
    logic [BW-1:0]       beep_nxt;
    logic [1:0]          level_nxt;
    logic                buzz_nxt;
    logic [CW-1:0]       avg_ext;

    // A zero width means no echo came back; treat it as "as far as possible".
    assign sample_cond = (pulse_in == '0) ? PW_MAX : pulse_in;
    assign stale_hit   = tick_us && !pulse_valid && (stale_cnt == STALE_LAST);
    assign avg_ext     = {1'b0, avg_us};

    // Stage 1: running-sum moving average over the last DEPTH samples.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || stale_hit) begin
            for (int i = 0; i < DEPTH; i++) sample_buf[i] <= PW_MAX;
            sum      <= SUM_FULL;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pulse_valid;
            if (pulse_valid) begin
                for (int i = DEPTH - 1; i > 0; i--) sample_buf[i] <= sample_buf[i-1];
                sample_buf[0] <= sample_cond;
                sum <= sum + SW'(sample_cond) - SW'(sample_buf[DEPTH-1]);
            end
        end
    end

    // Stage 2: truncating divide by the depth; a stale event parks avg at max silently.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || stale_hit) begin
            avg_us    <= PW_MAX;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= s1_valid;
            if (s1_valid) avg_us <= sum[SW-1:AVG_LOG2];
        end
    end

    // Zone next-state with hysteresis, plus beep counter and buzzer drive.
    always_comb begin
        level_nxt = level;
        if (avg_valid) begin
            case (level)
                LVL_CLEAR: begin
                    if (avg_ext < NEAR_ENTER)     level_nxt = LVL_NEAR;
                    else if (avg_ext < FAR_ENTER) level_nxt = LVL_FAR;
                end
                LVL_FAR: begin
                    if (avg_ext < NEAR_ENTER)     level_nxt = LVL_NEAR;
                    else if (avg_ext >= FAR_EXIT) level_nxt = LVL_CLEAR;
                end
                LVL_NEAR: begin
                    if (avg_ext >= FAR_EXIT)       level_nxt = LVL_CLEAR;
                    else if (avg_ext >= NEAR_EXIT) level_nxt = LVL_FAR;
                end
                default: level_nxt = LVL_CLEAR;
            endcase
        end
        if (stale_hit) level_nxt = LVL_CLEAR;

        // Counter restarts on every entry into FAR so the first beep starts immediately.
        beep_nxt = beep_cnt;
        if (level_nxt != LVL_FAR || level != LVL_FAR) beep_nxt = '0;
        else if (tick_us) beep_nxt = (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + 1'b1;

        buzz_nxt = (level_nxt == LVL_NEAR) ||
                   ((level_nxt == LVL_FAR) && (beep_nxt < BEEP_ON));
    end

    // Stage 3: register zone, alert, beep phase and buzzer together.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            level    <= LVL_CLEAR;
            alert    <= 1'b0;
            buzz     <= 1'b0;
            beep_cnt <= '0;
        end else begin
            level    <= level_nxt;
            alert    <= (level_nxt == LVL_NEAR);
            buzz     <= buzz_nxt;
            beep_cnt <= beep_nxt;
        end
    end

    // Stale watchdog: microseconds since the last sample, saturating; a sample wins over a tick.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else begin
            if (pulse_valid) begin
                stale_cnt <= '0;
                stale     <= 1'b0;
            end else if (tick_us && stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
                if (stale_hit) stale <= 1'b1;
            end
        end
    end

`ifdef PROX_DIST_CM_EN
    localparam int DCW = $clog2(PW_WIDTH);
    localparam logic [6:0] DIVISOR = 7'd58;

    logic [PW_WIDTH-1:0] div_q;
    logic [5:0]          div_rem;
    logic [DCW-1:0]      div_cnt;
    logic                div_busy;
    logic [6:0]          rem_sh;
    logic [6:0]          rem_diff;
    logic                rem_ge;
    logic [5:0]          rem_nxt;
    logic [PW_WIDTH-1:0] q_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh   = {div_rem, div_q[PW_WIDTH-1]};
        rem_diff = rem_sh - DIVISOR;
        rem_ge   = (rem_sh >= DIVISOR);
        rem_nxt  = rem_ge ? rem_diff[5:0] : rem_sh[5:0];
        q_nxt    = {div_q[PW_WIDTH-2:0], rem_ge};
    end

    // Serial divider; a fresh average restarts it so an aborted result never escapes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            div_q      <= '0;
            div_rem    <= '0;
            div_cnt    <= '0;
            div_busy   <= 1'b0;
            dist_cm    <= '0;
            dist_valid <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            if (avg_valid) begin
                div_q    <= avg_us;
                div_rem  <= '0;
                div_cnt  <= DCW'(PW_WIDTH - 1);
                div_busy <= 1'b1;
            end else if (div_busy) begin
                div_q   <= q_nxt;
                div_rem <= rem_nxt;
                div_cnt <= div_cnt - 1'b1;
                if (div_cnt == '0) begin
                    div_busy   <= 1'b0;
                    dist_valid <= 1'b1;
                    dist_cm    <= (q_nxt > PW_WIDTH'(1023)) ? 10'd1023 : q_nxt[9:0];
                end
            end
        end
    end
`else
    assign dist_cm    = '0;
    assign dist_valid = 1'b0;
`endif

endmodule

// File: tb/tb_proximity_alert.sv
// tb_proximity_alert: table-driven and hand-sequenced checks of proximity_alert.
// Timer parameters are scaled down so stale and beep behaviour fit a short run.
module tb_proximity_alert;

  localparam int PW    = 15;
  localparam int STALE = 3000;
  localparam int BON   = 200;
  localparam int BPER  = 1000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          tick_us = 1'b1;
  logic [PW-1:0] pulse_in = '0;
  logic          pulse_valid = 1'b0;
  logic [PW-1:0] avg_us;
  logic          avg_valid;
  logic [1:0]    level;
  logic          alert;
  logic          buzz;
  logic          stale;
  logic [9:0]    dist_cm;
  logic          dist_valid;

  proximity_alert #(
    .STALE_US       (STALE),
    .BEEP_ON_US     (BON),
    .BEEP_PERIOD_US (BPER)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tick_us     (tick_us),
    .pulse_in    (pulse_in),
    .pulse_valid (pulse_valid),
    .avg_us      (avg_us),
    .avg_valid   (avg_valid),
    .level       (level),
    .alert       (alert),
    .buzz        (buzz),
    .stale       (stale),
    .dist_cm     (dist_cm),
    .dist_valid  (dist_valid)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_avg_cyc = 0;
  logic [PW-1:0] exp_q[$];
  logic [9:0] dist_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PW-1:0] pulse;
    logic [PW-1:0] avg;
    logic [1:0]    lvl;
    logic          bz;
  } vec_t;
  vec_t tbl [24];
  int n_vec = 0;

  logic [PW-1:0] m_buf [4];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int p, input int a, input int l, input int b);
    tbl[n_vec] = '{PW'(p), PW'(a), 2'(l), 1'(b)};
    n_vec++;
  endtask

  // reference model of the averaging window
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_buf[i] = 15'h7fff;
  endfunction

  function automatic logic [PW-1:0] model_step(input logic [PW-1:0] v);
    int s;
    for (int i = 3; i > 0; i--) m_buf[i] = m_buf[i-1];
    m_buf[0] = (v == 0) ? 15'h7fff : v;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(m_buf[i]);
    return PW'(s / 4);
  endfunction

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] v, input logic [PW-1:0] e);
    pulse_in = v;
    pulse_valid = 1'b1;
    exp_q.push_back(e);
    step(1);
    pulse_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [PW-1:0] v);
    pulse_in = v;
    pulse_valid = 1'b1;
    step(1);
    pulse_valid = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    pulse_valid = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  // scoreboard: every avg_valid must match the oldest expected average
  always @(negedge sys_clk) begin
    if (avg_valid) begin
      last_avg_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL avg_unexpected: got avg_valid with avg_us=%0d, expected no strobe", avg_us);
      end else begin
        check("avg_us", int'(avg_us), int'(exp_q.pop_front()));
      end
    end
  end

`ifdef PROX_DIST_CM_EN
  always @(negedge sys_clk) begin
    if (dist_valid) begin
      check("dist_latency", cyc - last_avg_cyc, 16);
      if (dist_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dist_unexpected: got dist_valid with dist_cm=%0d, expected no strobe", dist_cm);
      end else begin
        check("dist_cm", int'(dist_cm), int'(dist_q.pop_front()));
      end
    end
  end
`else
  int dist_noise = 0;
  always @(negedge sys_clk) if (dist_valid || dist_cm != '0) dist_noise++;
`endif

  initial begin
    int bad;
    int stray;

    // 1000 x4 from reset: slow descent into FAR
    add_vec(1000, 24825, 0, 0); add_vec(1000, 16883, 0, 0);
    add_vec(1000,  8941, 0, 0); add_vec(1000,  1000, 1, 1);
    // 500 x4: FAR until the average drops under 580
    add_vec(500, 875, 1, 1); add_vec(500, 750, 1, 1);
    add_vec(500, 625, 1, 1); add_vec(500, 500, 2, 1);
    // 620 x4: inside the NEAR hysteresis band (< 696)
    add_vec(620, 530, 2, 1); add_vec(620, 560, 2, 1);
    add_vec(620, 590, 2, 1); add_vec(620, 620, 2, 1);
    // 700 x4: leaves NEAR only once avg >= 696
    add_vec(700, 640, 2, 1); add_vec(700, 660, 2, 1);
    add_vec(700, 680, 2, 1); add_vec(700, 700, 1, 1);
    // back to NEAR at 500
    add_vec(500, 650, 1, 1); add_vec(500, 600, 1, 1);
    add_vec(500, 550, 2, 1); add_vec(500, 500, 2, 1);
    // no-echo samples push the average to the maximum
    add_vec(0,  8566, 0, 0); add_vec(0, 16633, 0, 0);
    add_vec(0, 24700, 0, 0); add_vec(0, 32767, 0, 0);

    // reset values
    step(3);
    check("rst_avg_us", int'(avg_us), 32767);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_alert", int'(alert), 0);
    check("rst_buzz", int'(buzz), 0);
    check("rst_stale", int'(stale), 0);
    check("rst_dist_cm", int'(dist_cm), 0);
    check("rst_dist_valid", int'(dist_valid), 0);
    sys_rst_n = 1'b1;
    model_reset();

    // table-driven zone walk
    for (int i = 0; i < n_vec; i++) begin
      void'(model_step(tbl[i].pulse));
      send(tbl[i].pulse, tbl[i].avg);
      step(2);
      check($sformatf("row%0d_level", i), int'(level), int'(tbl[i].lvl));
      check($sformatf("row%0d_alert", i), int'(alert), (tbl[i].lvl == 2'd2) ? 1 : 0);
      check($sformatf("row%0d_buzz", i), int'(buzz), int'(tbl[i].bz));
    end

    // FAR beep cadence, with samples sent back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) send(15'd1000, model_step(15'd1000));
    step(2);
    check("far_entry_level", int'(level), 1);
    check("far_entry_buzz", int'(buzz), 1);
    bad = 0;
    for (int k = 1; k <= 1099; k++) begin
      step(1);
      if (buzz !== (((k % BPER) < BON) ? 1'b1 : 1'b0)) bad++;
    end
    check("beep_pattern_bad_cycles", bad, 0);
    check("beep_second_on", int'(buzz), 1);

    // reset with a sample in flight while beeping
    send_raw(15'd700);
    sys_rst_n = 1'b0;
    step(1);
    check("midrst_avg_us", int'(avg_us), 32767);
    check("midrst_avg_valid", int'(avg_valid), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_alert", int'(alert), 0);
    check("midrst_buzz", int'(buzz), 0);
    check("midrst_stale", int'(stale), 0);
    sys_rst_n = 1'b1;
    model_reset();
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (avg_valid) stray++;
    end
    check("midrst_no_avg_valid", stray, 0);
    send(15'd1000, model_step(15'd1000));
    step(3);
    check("midrst_first_avg", int'(avg_us), 24825);

    // stale sensor while NEAR
    do_reset();
    for (int i = 0; i < 4; i++) send(15'd500, model_step(15'd500));
    step(STALE - 1);
    check("prestale_stale", int'(stale), 0);
    check("prestale_level", int'(level), 2);
    check("prestale_buzz", int'(buzz), 1);
    step(1);
    check("stale_flag", int'(stale), 1);
    check("stale_level", int'(level), 0);
    check("stale_alert", int'(alert), 0);
    check("stale_buzz", int'(buzz), 0);
    check("stale_avg_us", int'(avg_us), 32767);
    model_reset();
    send(15'd1000, model_step(15'd1000));
    check("stale_cleared", int'(stale), 0);
    step(3);
    check("stale_recover_avg", int'(avg_us), 24825);
    check("stale_recover_level", int'(level), 0);

`ifdef PROX_DIST_CM_EN
    // avg 1160 -> 20 cm
    do_reset();
    send(15'd2321, model_step(15'd2321));
    for (int i = 0; i < 3; i++) send(15'd773, model_step(15'd773));
    dist_q.push_back(10'd20);
    step(25);
    check("dist_a_drained", dist_q.size(), 0);
    // second average (580) five cycles after 1160 aborts the first divide
    do_reset();
    send(15'd2321, model_step(15'd2321));
    for (int i = 0; i < 3; i++) send(15'd773, model_step(15'd773));
    step(4);
    send(15'd1, model_step(15'd1));
    dist_q.push_back(10'd10);
    step(25);
    check("dist_b_drained", dist_q.size(), 0);
`else
    check("dist_idle_events", dist_noise, 0);
`endif

    step(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
